self_attention_sched: RTL and testbench
=======================================

SELF_ATTENTION_SCHED -- requirements
Module: self_attention_sched

Interface
- REQ-001: Parameter NUM_ROWS, default 4: number of parallel softmax rows; legal range ≥ 2.
- REQ-002: Parameter NUM_TILES, default 2: number of R2B tile converters; legal range 1..NUM_ROWS.
- REQ-003: Parameter NUM_SLICES, default 2: number of R2B slices per head before completion; legal range ≥ 1.
- REQ-004: Local RW = $clog2(NUM_ROWS)+1, the row-index width.
- REQ-005: Local GPMAX = NUM_ROWS+NUM_TILES-1.
- REQ-006: Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- REQ-007: clk  in  1  sole clock, rising edge.
- REQ-008: rst_n  in  1  asynchronous active-low reset.
- REQ-009: start  in  1  begin one head; sampled in IDLE only.
- REQ-010: in_valid_b2r  in  1  B2R wrapper has data.
- REQ-011: out_ready_b2r  in  1  B2R wrapper presenting a row word this cycle.
- REQ-012: slice_done_b2r  in  1  B2R slice finished.
- REQ-013: softmax_done  in  NUM_ROWS  per-row softmax finished.
- REQ-014: softmax_out_valid  in  NUM_ROWS  per-row softmax output valid.
- REQ-015: slice_last_r2b  in  NUM_TILES  per-tile last beat of slice.
- REQ-016: internal_rst_n_b2r  out  1  B2R local reset, active-low.
- REQ-017: internal_rst_n_softmax  out  NUM_ROWS  per-row softmax local reset, active-low.
- REQ-018: softmax_en  out  1  softmax enable.
- REQ-019: softmax_valid  out  NUM_ROWS  one-hot row-input strobe.
- REQ-020: r2b_row_idx  out  NUM_TILES*RW  packed row index per tile; tile m occupies bits [m*RW +: RW].
- REQ-021: in_valid_r2b  out  NUM_TILES  per-tile input valid.
- REQ-022: internal_rst_n_r2b  out  NUM_TILES  per-tile R2B local reset, active-low.
- REQ-023: slice_cnt  out  $clog2(NUM_SLICES+1)  completed slices.
- REQ-024: busy  out  1  high in every state other than IDLE.
- REQ-025: done  out  1  one-cycle completion pulse.

Function
- REQ-026: The FSM SHALL have states IDLE, WAIT, STREAM and DONE.
- REQ-027: Transitions SHALL be: IDLE->WAIT on start; WAIT->STREAM on in_valid_b2r; STREAM->DONE when slice_last_r2b[NUM_TILES-1] is high and slice_cnt==NUM_SLICES-1; DONE->IDLE unconditionally.
- REQ-028: softmax_en SHALL be set on the WAIT->STREAM transition and cleared on entering IDLE.
- REQ-029: Row pointer vp (0..NUM_ROWS-1) SHALL advance only in STREAM with out_ready_b2r high, wrapping from NUM_ROWS-1 to 0; no out-of-range value SHALL ever occur.
- REQ-030: softmax_valid SHALL be registered with 1-cycle latency: one-hot(vp) when STREAM and out_ready_b2r in the prior cycle, else all-zero.
- REQ-031: Diagonal pointer gp SHALL increment when any softmax_out_valid bit is high, saturate at GPMAX, and clear to 0 on each slice boundary (slice_last_r2b[NUM_TILES-1]).
- REQ-032: Tile m SHALL be active iff m ≤ gp < m+NUM_ROWS. When active: r2b_row_idx[m]=gp-m and in_valid_r2b[m]=softmax_out_valid[gp-m], both combinational. When inactive: index 0 and valid 0.
- REQ-033: slice_cnt SHALL increment on slice_last_r2b[NUM_TILES-1] in STREAM and clear on entering IDLE.
- REQ-034: If STREAM->DONE coincides with any_softmax_valid, the slice-boundary clear of gp SHALL win.
- REQ-035: internal_rst_n_b2r SHALL be registered ~slice_done_b2r.
- REQ-036: internal_rst_n_softmax[r] SHALL be registered ~softmax_done[r].
- REQ-037: internal_rst_n_r2b[m] SHALL be registered ~slice_last_r2b[m].
- REQ-038: done SHALL be high exactly during the DONE state.
- REQ-039: start received outside IDLE SHALL be ignored.

Reset
- REQ-040: rst_n low SHALL asynchronously force IDLE and clear vp, gp, slice_cnt, softmax_en, softmax_valid, busy and done to 0.
- REQ-041: rst_n low SHALL asynchronously force all internal_rst_n_* outputs to 0.
- REQ-042: Reset mid-STREAM SHALL abort the head with no done pulse.
- REQ-043: After rst_n deasserts, the first state change SHALL occur only on a subsequent start.

Configuration
- REQ-044: Macro SA_SCHED_STALL_CNT_EN SHALL, when defined, add output stall_cycles (32 bits) counting STREAM cycles with out_ready_b2r low.
- REQ-045: stall_cycles SHALL saturate at all-ones, clear on start, and reset to 0.
- REQ-046: Without SA_SCHED_STALL_CNT_EN, the stall_cycles port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
- REQ-047: Defaults; start, then in_valid_b2r, then out_ready_b2r held for 6 cycles -> softmax_valid sequence 0001, 0010, 0100, 1000, 0001, 0010, each 1 cycle after ready.
- REQ-048: softmax_out_valid=1111 for 5 cycles -> gp goes 1..5 and saturates at 5; with gp=1: tile0 idx 1 valid, tile1 idx 0 valid; with gp=4: tile0 inactive, tile1 idx 3.
- REQ-049: Two slice_last_r2b[1] pulses in STREAM -> slice_cnt becomes 1 then DONE, done high for 1 cycle, busy low on the next cycle.
- REQ-050: rst_n pulsed low mid-STREAM, asynchronously between clock edges -> all outputs 0 immediately, state IDLE, no done pulse.
- REQ-051: slice_done_b2r=1 and softmax_done=0100 for 1 cycle -> internal_rst_n_b2r=0 and internal_rst_n_softmax=1011 for exactly the following cycle.
- REQ-052: With SA_SCHED_STALL_CNT_EN defined, 3 STREAM cycles with out_ready_b2r low -> stall_cycles=3; a subsequent start clears it to 0.

Source files
------------

// File: rtl/self_attention_sched.sv
// Scheduler for one self-attention head: B2R row streaming, softmax row strobes and
// diagonal R2B tile hand-off. Optional stall counter enabled by SA_SCHED_STALL_CNT_EN.
module self_attention_sched #(
  parameter  int NUM_ROWS   = 4,
  parameter  int NUM_TILES  = 2,
  parameter  int NUM_SLICES = 2,
  localparam int RW         = $clog2(NUM_ROWS) + 1,
  localparam int SW         = $clog2(NUM_SLICES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid_b2r,
  input  logic                    out_ready_b2r,
  input  logic                    slice_done_b2r,
  input  logic [NUM_ROWS-1:0]     softmax_done,
  input  logic [NUM_ROWS-1:0]     softmax_out_valid,
  input  logic [NUM_TILES-1:0]    slice_last_r2b,
  output logic                    internal_rst_n_b2r,
  output logic [NUM_ROWS-1:0]     internal_rst_n_softmax,
  output logic                    softmax_en,
  output logic [NUM_ROWS-1:0]     softmax_valid,
  output logic [NUM_TILES*RW-1:0] r2b_row_idx,
  output logic [NUM_TILES-1:0]    in_valid_r2b,
  output logic [NUM_TILES-1:0]    internal_rst_n_r2b,
  output logic [SW-1:0]           slice_cnt,
`ifdef SA_SCHED_STALL_CNT_EN
  output logic [31:0]             stall_cycles,
`endif
  output logic                    busy,
  output logic                    done
);

  localparam int GPMAX = NUM_ROWS + NUM_TILES - 1;
  localparam int VW    = $clog2(NUM_ROWS);
  localparam int GW    = $clog2(GPMAX + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [VW-1:0] vp;
  logic [GW-1:0] gp;
  logic          stream_adv;
  logic          slice_boundary;

  assign stream_adv     = (state == STREAM) && out_ready_b2r;
  assign slice_boundary = slice_last_r2b[NUM_TILES-1];
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WAIT;
      WAIT:    if (in_valid_b2r) state_nxt = STREAM;
      STREAM:  if (slice_boundary && slice_cnt == SW'(NUM_SLICES - 1)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      softmax_en             <= 1'b0;
      vp                     <= '0;
      softmax_valid          <= '0;
      gp                     <= '0;
      slice_cnt              <= '0;
      internal_rst_n_b2r     <= 1'b0;
      internal_rst_n_softmax <= '0;
      internal_rst_n_r2b     <= '0;
    end else begin
      state <= state_nxt;

      if (state == WAIT && in_valid_b2r) softmax_en <= 1'b1;
      else if (state == DONE)            softmax_en <= 1'b0;

      softmax_valid <= stream_adv ? (NUM_ROWS'(1) << vp) : '0;
      if (stream_adv) vp <= (vp == VW'(NUM_ROWS - 1)) ? '0 : vp + 1'b1;

      // A slice boundary clears the diagonal even when outputs arrive in the same cycle.
      if (slice_boundary)                                gp <= '0;
      else if (|softmax_out_valid && gp != GW'(GPMAX))   gp <= gp + 1'b1;

      if (state == DONE)                        slice_cnt <= '0;
      else if (state == STREAM && slice_boundary) slice_cnt <= slice_cnt + 1'b1;

      internal_rst_n_b2r     <= ~slice_done_b2r;
      internal_rst_n_softmax <= ~softmax_done;
      internal_rst_n_r2b     <= ~slice_last_r2b;
    end
  end

  // Tile m works the diagonal row gp-m while that row exists.
  always_comb begin
    r2b_row_idx  = '0;
    in_valid_r2b = '0;
    for (int m = 0; m < NUM_TILES; m++) begin
      if (int'(gp) >= m && int'(gp) < m + NUM_ROWS) begin
        r2b_row_idx[m*RW +: RW] = RW'(int'(gp) - m);
        in_valid_r2b[m]         = |(softmax_out_valid & (NUM_ROWS'(1) << (int'(gp) - m)));
      end
    end
  end

`ifdef SA_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           stall_cycles <= '0;
    else if (state == IDLE && start)                      stall_cycles <= '0;
    else if (state == STREAM && !out_ready_b2r && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_self_attention_sched.sv
// Self-checking bench for self_attention_sched (default parameters) against a
// behavioural model of the head schedule; covers SA_SCHED_STALL_CNT_EN when defined.
module tb_self_attention_sched;

  localparam int NR    = 4;
  localparam int NT    = 2;
  localparam int NS    = 2;
  localparam int RW    = 3;
  localparam int SW    = 2;
  localparam int GPMAX = NR + NT - 1;

  logic            clk, rst_n, start, in_valid_b2r, out_ready_b2r, slice_done_b2r;
  logic [NR-1:0]   softmax_done, softmax_out_valid;
  logic [NT-1:0]   slice_last_r2b;
  logic            internal_rst_n_b2r, softmax_en, busy, done;
  logic [NR-1:0]   internal_rst_n_softmax, softmax_valid;
  logic [NT*RW-1:0] r2b_row_idx;
  logic [NT-1:0]   in_valid_r2b, internal_rst_n_r2b;
  logic [SW-1:0]   slice_cnt;
`ifdef SA_SCHED_STALL_CNT_EN
  logic [31:0]     stall_cycles;
`endif

  self_attention_sched #(.NUM_ROWS(NR), .NUM_TILES(NT), .NUM_SLICES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid_b2r(in_valid_b2r),
    .out_ready_b2r(out_ready_b2r), .slice_done_b2r(slice_done_b2r),
    .softmax_done(softmax_done), .softmax_out_valid(softmax_out_valid),
    .slice_last_r2b(slice_last_r2b), .internal_rst_n_b2r(internal_rst_n_b2r),
    .internal_rst_n_softmax(internal_rst_n_softmax), .softmax_en(softmax_en),
    .softmax_valid(softmax_valid), .r2b_row_idx(r2b_row_idx), .in_valid_r2b(in_valid_r2b),
    .internal_rst_n_r2b(internal_rst_n_r2b), .slice_cnt(slice_cnt),
`ifdef SA_SCHED_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the head schedule.
  typedef enum int {S_IDLE, S_WAIT, S_STREAM, S_DONE} mstate_t;
  mstate_t     m_st;
  int          m_vp, m_gp, m_cnt;
  bit          m_en, m_irb;
  logic [NR-1:0] m_sv, m_irs;
  logic [NT-1:0] m_irr;
  longint      m_stall;

  task automatic model_reset();
    m_st = S_IDLE; m_vp = 0; m_gp = 0; m_cnt = 0; m_en = 0; m_irb = 0;
    m_sv = '0; m_irs = '0; m_irr = '0; m_stall = 0;
  endtask

  task automatic model_update();
    mstate_t ns = m_st;
    bit last = slice_last_r2b[NT-1];
    case (m_st)
      S_IDLE:   if (start) ns = S_WAIT;
      S_WAIT:   if (in_valid_b2r) ns = S_STREAM;
      S_STREAM: if (last && m_cnt == NS - 1) ns = S_DONE;
      S_DONE:   ns = S_IDLE;
    endcase
    if (m_st == S_WAIT && in_valid_b2r) m_en = 1;
    if (m_st == S_DONE) m_en = 0;
    m_sv = '0;
    if (m_st == S_STREAM && out_ready_b2r) begin
      m_sv[m_vp] = 1'b1;
      m_vp = (m_vp + 1) % NR;
    end
    if (last) m_gp = 0;
    else if (softmax_out_valid != 0 && m_gp < GPMAX) m_gp = m_gp + 1;
    if (m_st == S_DONE) m_cnt = 0;
    else if (m_st == S_STREAM && last) m_cnt = m_cnt + 1;
    if (m_st == S_IDLE && start) m_stall = 0;
    else if (m_st == S_STREAM && !out_ready_b2r && m_stall < 64'hFFFF_FFFF) m_stall = m_stall + 1;
    m_irb = ~slice_done_b2r;
    m_irs = ~softmax_done;
    m_irr = ~slice_last_r2b;
    m_st  = ns;
  endtask

  task automatic check_all();
    logic [NT*RW-1:0] e_idx = '0;
    logic [NT-1:0]    e_iv  = '0;
    for (int m = 0; m < NT; m++)
      if (m <= m_gp && m_gp < m + NR) begin
        e_idx[m*RW +: RW] = RW'(m_gp - m);
        e_iv[m]           = softmax_out_valid[m_gp - m];
      end
    n_vec++; if (busy !== (m_st != S_IDLE)) begin n_err++; $display("FAIL busy: got %b want %b", busy, m_st != S_IDLE); end
    n_vec++; if (done !== (m_st == S_DONE)) begin n_err++; $display("FAIL done: got %b want %b", done, m_st == S_DONE); end
    n_vec++; if (softmax_en !== m_en) begin n_err++; $display("FAIL softmax_en: got %b want %b", softmax_en, m_en); end
    n_vec++; if (softmax_valid !== m_sv) begin n_err++; $display("FAIL softmax_valid: got %b want %b", softmax_valid, m_sv); end
    n_vec++; if (r2b_row_idx !== e_idx) begin n_err++; $display("FAIL r2b_row_idx: got %h want %h", r2b_row_idx, e_idx); end
    n_vec++; if (in_valid_r2b !== e_iv) begin n_err++; $display("FAIL in_valid_r2b: got %b want %b", in_valid_r2b, e_iv); end
    n_vec++; if (slice_cnt !== SW'(m_cnt)) begin n_err++; $display("FAIL slice_cnt: got %0d want %0d", slice_cnt, m_cnt); end
    n_vec++; if (internal_rst_n_b2r !== m_irb) begin n_err++; $display("FAIL rst_b2r: got %b want %b", internal_rst_n_b2r, m_irb); end
    n_vec++; if (internal_rst_n_softmax !== m_irs) begin n_err++; $display("FAIL rst_softmax: got %b want %b", internal_rst_n_softmax, m_irs); end
    n_vec++; if (internal_rst_n_r2b !== m_irr) begin n_err++; $display("FAIL rst_r2b: got %b want %b", internal_rst_n_r2b, m_irr); end
`ifdef SA_SCHED_STALL_CNT_EN
    n_vec++; if (stall_cycles !== m_stall[31:0]) begin n_err++; $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, m_stall); end
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_update();
    #1;
    check_all();
  endtask

  task automatic clear_inputs();
    start = 0; in_valid_b2r = 0; out_ready_b2r = 0; slice_done_b2r = 0;
    softmax_done = '0; softmax_out_valid = '0; slice_last_r2b = '0;
  endtask

  task automatic go_stream();
    start = 1; step(); start = 0;
    in_valid_b2r = 1; step(); in_valid_b2r = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #2;
    model_reset();
    check_all();
    step(); step();
    #2 rst_n = 1;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_stream_rows();
    logic [NR-1:0] ev;
    go_stream();
    out_ready_b2r = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      ev = 4'b0001 << (i % 4);
      n_vec++; if (softmax_valid !== ev) begin n_err++; $display("FAIL row_seq[%0d]: got %b want %b", i, softmax_valid, ev); end
    end
    out_ready_b2r = 0;
    step();
  endtask

  task automatic test_diagonal();
    softmax_out_valid = 4'b1111;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) begin
        n_vec++; if (r2b_row_idx !== 6'b000_001 || in_valid_r2b !== 2'b11) begin
          n_err++; $display("FAIL diag_gp1: got idx %b v %b want idx 000001 v 11", r2b_row_idx, in_valid_r2b); end
      end
      if (k == 4) begin
        n_vec++; if (r2b_row_idx !== 6'b011_000 || in_valid_r2b !== 2'b10) begin
          n_err++; $display("FAIL diag_gp4: got idx %b v %b want idx 011000 v 10", r2b_row_idx, in_valid_r2b); end
      end
      if (k == 6) begin
        n_vec++; if (r2b_row_idx !== 6'b000_000 || in_valid_r2b !== 2'b00) begin
          n_err++; $display("FAIL diag_sat: got idx %b v %b want idx 000000 v 00", r2b_row_idx, in_valid_r2b); end
      end
    end
    softmax_out_valid = '0;
    step();
  endtask

  task automatic test_local_resets();
    slice_done_b2r = 1; softmax_done = 4'b0100;
    step();
    n_vec++; if (internal_rst_n_b2r !== 1'b0 || internal_rst_n_softmax !== 4'b1011) begin
      n_err++; $display("FAIL local_rst_assert: got %b/%b want 0/1011", internal_rst_n_b2r, internal_rst_n_softmax); end
    slice_done_b2r = 0; softmax_done = '0;
    step();
    n_vec++; if (internal_rst_n_b2r !== 1'b1 || internal_rst_n_softmax !== 4'b1111) begin
      n_err++; $display("FAIL local_rst_release: got %b/%b want 1/1111", internal_rst_n_b2r, internal_rst_n_softmax); end
  endtask

  task automatic test_completion();
    int done_seen = 0;
    slice_last_r2b = 2'b10; step(); slice_last_r2b = '0;
    n_vec++; if (slice_cnt !== 2'd1 || done !== 1'b0) begin
      n_err++; $display("FAIL first_slice: got cnt %0d done %b want 1 0", slice_cnt, done); end
    step();
    slice_last_r2b = 2'b10; step(); slice_last_r2b = '0;
    n_vec++; if (done !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL done_pulse: got done %b busy %b want 1 1", done, busy); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) done_seen++;
    end
    n_vec++; if (busy !== 1'b0 || done_seen != 0) begin
      n_err++; $display("FAIL after_done: got busy %b extra done %0d want 0 0", busy, done_seen); end
  endtask

  task automatic test_stall();
`ifdef SA_SCHED_STALL_CNT_EN
    go_stream();
    for (int i = 0; i < 3; i++) step();
    n_vec++; if (stall_cycles !== 32'd3) begin n_err++; $display("FAIL stall_count: got %0d want 3", stall_cycles); end
    out_ready_b2r = 1;
    slice_last_r2b = 2'b10; step(); slice_last_r2b = '0; step();
    slice_last_r2b = 2'b10; step(); slice_last_r2b = '0; step();
    out_ready_b2r = 0;
    start = 1; step(); start = 0;
    n_vec++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL stall_clear: got %0d want 0", stall_cycles); end
    in_valid_b2r = 1; step(); in_valid_b2r = 0;
    slice_last_r2b = 2'b10; step(); step(); step(); slice_last_r2b = '0;
    step();
`endif
  endtask

  task automatic test_async_reset();
    int done_seen = 0;
    go_stream();
    out_ready_b2r = 1; softmax_out_valid = 4'b0011; step(); step();
    clear_inputs(); step();
    #3 rst_n = 0;
    #1;
    model_reset();
    check_all();
    n_vec++; if ({busy, done, softmax_en, softmax_valid, internal_rst_n_b2r, internal_rst_n_softmax,
                  internal_rst_n_r2b, slice_cnt, r2b_row_idx, in_valid_r2b} !== '0) begin
      n_err++; $display("FAIL async_reset_outputs: some output nonzero while rst_n low"); end
    step();
    #2 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || busy) done_seen++;
    end
    n_vec++; if (done_seen != 0) begin n_err++; $display("FAIL post_reset_idle: got %0d active cycles want 0", done_seen); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start             = ($urandom_range(7) == 0);
      in_valid_b2r      = $urandom_range(1);
      out_ready_b2r     = $urandom_range(1);
      slice_done_b2r    = ($urandom_range(3) == 0);
      softmax_done      = NR'($urandom);
      softmax_out_valid = NR'($urandom);
      slice_last_r2b    = {($urandom_range(5) == 0), ($urandom_range(5) == 0)};
      step();
    end
    clear_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_stream_rows();
    test_diagonal();
    test_local_resets();
    test_completion();
    test_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
